// File: rtl/change_dispenser_pkg.sv
// Shared vending constants, FSM encodings and the coin-selection helper
// used by the change dispenser and the vending-machine controller.
package change_dispenser_pkg;

    localparam logic [7:0] COIN_50    = 8'd50;
    localparam logic [7:0] COIN_10    = 8'd10;
    localparam logic [7:0] COIN_5     = 8'd5;
    localparam logic [7:0] MAX_AMOUNT = 8'd100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PAY  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CN_NONE = 2'd0,
        CN_50   = 2'd1,
        CN_10   = 2'd2,
        CN_5    = 2'd3
    } coin_e;

    // Largest coin that fits; remaining is always a multiple of 5, so no underflow.
    function automatic coin_e pick_coin(input logic [7:0] rem);
        coin_e c;
        c = CN_NONE;
        if (rem >= COIN_50)      c = CN_50;
        else if (rem >= COIN_10) c = CN_10;
        else if (rem != 8'd0)    c = CN_5;
        return c;
    endfunction

    function automatic logic [7:0] coin_value(input coin_e c);
        logic [7:0] v;
        v = 8'd0;
        case (c)
            CN_50:   v = COIN_50;
            CN_10:   v = COIN_10;
            CN_5:    v = COIN_5;
            default: v = 8'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/change_dispenser_pace_tick_gen.sv
// Coin pacing tick: one-cycle pulse every TICK_CYCLES clocks, restartable
// by a synchronous clear so the first tick lands exactly TICK_CYCLES after it.
module pace_tick_gen #(
    parameter int TICK_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q + CW'(1);
        tick_d = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: accepts a refund amount and pays it out largest coin first,
// one registered coin pulse per pacing tick, with progress and done reporting.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int TICK_CYCLES = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       refund_valid,
    input  logic [7:0] refund_amount,
    output logic       refund_ready,
    output logic       coin_50,
    output logic       coin_10,
    output logic       coin_5,
    output logic       busy,
    output logic       done,
    output logic [7:0] remaining,
    output logic [4:0] coin_count,
    output logic       amount_err
);

    // Handshake: an amount is taken on any rising edge where refund_valid and
    // refund_ready are both high; ready is a register, high only while idle,
    // and valid offered while not ready is dropped (upstream must hold it).
    state_e     state_q, state_d;
    logic [7:0] remaining_q, remaining_d;
    logic [4:0] count_q, count_d;
    logic       err_q, err_d;
    logic       ready_q, busy_q, done_q;
    logic       c50_q, c10_q, c5_q;

    logic       accept;
    logic       tick;
    logic       fire;
    logic [7:0] amt, amt_rem, amt_trunc;
    coin_e      coin;
    logic [7:0] coin_val;

    assign accept = refund_valid && ready_q;

    pace_tick_gen #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick (
        .clk     (clk),
        .rst_n   (rst),
        .clear_i (accept),
        .tick_o  (tick)
    );

    always_comb begin
        amt         = (refund_amount > MAX_AMOUNT) ? MAX_AMOUNT : refund_amount;
        amt_rem     = amt % 8'd5;
        amt_trunc   = amt - amt_rem;
        coin        = pick_coin(remaining_q);
        coin_val    = coin_value(coin);
        fire        = (state_q == ST_PAY) && tick && (coin != CN_NONE);

        state_d     = state_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        err_d       = err_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    remaining_d = amt_trunc;
                    err_d       = (refund_amount > MAX_AMOUNT) || (amt_rem != 8'd0);
                    count_d     = 5'd0;
                    state_d     = (amt_trunc != 8'd0) ? ST_PAY : ST_FIN;
                end
            end
            ST_PAY: begin
                // Finish one cycle after the last coin so done trails that pulse.
                if (remaining_q == 8'd0) begin
                    state_d = ST_FIN;
                end else if (fire) begin
                    remaining_d = remaining_q - coin_val;
                    count_d     = count_q + 5'd1;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= 8'd0;
            count_q     <= 5'd0;
            err_q       <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            c50_q       <= 1'b0;
            c10_q       <= 1'b0;
            c5_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            err_q       <= err_d;
            ready_q     <= (state_d == ST_IDLE);
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= (state_d == ST_FIN);
            c50_q       <= fire && (coin == CN_50);
            c10_q       <= fire && (coin == CN_10);
            c5_q        <= fire && (coin == CN_5);
        end
    end

    assign refund_ready = ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign coin_50      = c50_q;
    assign coin_10      = c10_q;
    assign coin_5       = c5_q;
    assign remaining    = remaining_q;
    assign coin_count   = count_q;
    assign amount_err   = err_q;

endmodule
